// File: rtl/spipoti_ramp.sv
// Slew-rate limiter in front of the SPI digital-pot writer: walks 'value' toward a clamped
// target by at most STEP every DIVIDER enabled clock cycles, flagging busy and a done pulse.
module spipoti_ramp #(
  parameter int WIDTH      = 8,
  parameter int DIVIDER    = 100000,
  parameter int STEP       = 1,
  parameter int MIN_VALUE  = 0,
  parameter int MAX_VALUE  = 255,
  parameter int INIT_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target,
  input  logic             target_load,
  input  logic             enable,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done
);

  localparam int TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(DIVIDER - 1);
  localparam logic [WIDTH:0] STEP_WIDE = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam int INIT_CLAMPED = (INIT_VALUE < MIN_VALUE) ? MIN_VALUE :
                                (INIT_VALUE > MAX_VALUE) ? MAX_VALUE : INIT_VALUE;
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_CLAMPED);

  typedef enum logic {S_IDLE, S_RAMP} state_t;

  // Compared as int so the bounds never fold into a constant unsigned comparison.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x);
    int xi;
    xi = int'(x);
    if (xi < MIN_VALUE) return WIDTH'(MIN_VALUE);
    if (xi > MAX_VALUE) return WIDTH'(MAX_VALUE);
    return x;
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] tgt_q;
  logic [TW-1:0]    timer_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] tgt_d;
  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] stepped_d;
  logic [WIDTH:0]   dist_d;
  logic             close_d;
  logic             tick_d;
  logic             step_now_d;

  always_comb begin
    tgt_d   = target_load ? clamp(target) : tgt_q;
    tick_d  = (timer_q == '0);
    // Distance in WIDTH+1 bits so neither direction can wrap.
    if (tgt_q >= value_q) dist_d = {1'b0, tgt_q} - {1'b0, value_q};
    else                  dist_d = {1'b0, value_q} - {1'b0, tgt_q};
    close_d = (dist_d <= STEP_WIDE);
    if (close_d)              stepped_d = tgt_q;
    else if (tgt_q > value_q) stepped_d = value_q + STEP_V;
    else                      stepped_d = value_q - STEP_V;
    step_now_d = (state_q == S_RAMP) && enable && tick_d;
    value_d    = step_now_d ? stepped_d : value_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      value_q <= INIT_V;
      tgt_q   <= INIT_V;
      timer_q <= TIMER_RELOAD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tgt_q   <= tgt_d;
      value_q <= value_d;
      busy_q  <= (tgt_d != value_d);
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= TIMER_RELOAD;
          if (tgt_d != value_q) state_q <= S_RAMP;
        end
        S_RAMP: begin
          if (step_now_d) begin
            timer_q <= TIMER_RELOAD;
            // Arrival with a fresh, different target loaded on the same edge keeps ramping.
            if (close_d && (tgt_d == value_d)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end else if (tgt_q == value_q) begin
            timer_q <= TIMER_RELOAD;
            if (tgt_d == value_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end else if (enable) begin
            timer_q <= timer_q - TW'(1);
          end
        end
      endcase
    end
  end

  assign value = value_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_spipoti_ramp.sv
// Bench for spipoti_ramp: a directed vector table, hand-written corner sequences and a
// randomized run checked cycle-by-cycle against a count-up behavioural model.
module tb_spipoti_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a_target, b_target;
  logic       a_ld, b_ld, a_en, b_en;
  logic [7:0] a_value, b_value;
  logic       a_busy, b_busy, a_done, b_done;

  // A: DIVIDER=4, STEP=1, full range.  B: DIVIDER=3, STEP=5, clamped 10..200, INIT below range.
  spipoti_ramp #(.WIDTH(8), .DIVIDER(4), .STEP(1), .MIN_VALUE(0), .MAX_VALUE(255),
                 .INIT_VALUE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .target(a_target), .target_load(a_ld), .enable(a_en),
    .value(a_value), .busy(a_busy), .done(a_done));

  spipoti_ramp #(.WIDTH(8), .DIVIDER(3), .STEP(5), .MIN_VALUE(10), .MAX_VALUE(200),
                 .INIT_VALUE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .target(b_target), .target_load(b_ld), .enable(b_en),
    .value(b_value), .busy(b_busy), .done(b_done));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for a done pulse (sel 0 = A, 1 = B); also watches B's value range.
  task automatic wait_done(input bit sel, input int maxc, output int n);
    bit range_ok;
    range_ok = 1'b1;
    n = 0;
    while (((sel ? b_done : a_done) !== 1'b1) && n < maxc) begin
      tick_n(1);
      n++;
      if (sel && (b_value < 8'd10 || b_value > 8'd200)) range_ok = 1'b0;
    end
    chk(sel ? "b_done_within_bound" : "a_done_within_bound", sel ? b_done : a_done, 1);
    if (sel) chk("b_value_in_range", range_ok, 1);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] tgt;
    logic       en;
    logic [7:0] ev;
    logic       eb;
    logic       ed;
  } vec_t;

  function automatic vec_t mkv(input logic ld, input logic [7:0] tgt, input logic [7:0] ev,
                               input logic eb, input logic ed);
    vec_t v;
    v.ld = ld; v.tgt = tgt; v.en = 1'b1; v.ev = ev; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  typedef struct {
    int v;
    int t;
    bit ramp;
    int el;
    bit busy;
    bit done;
  } mstate_t;

  // One clock of the rules: step every div-th enabled ramping cycle, overshoot-free,
  // step uses the target held before this edge, loads are clamped.
  function automatic mstate_t mstep(input mstate_t s, input bit ld, input int tg, input bit en,
                                    input int div, input int stp, input int mn, input int mx);
    int nt;
    int diff;
    nt = ld ? ((tg < mn) ? mn : ((tg > mx) ? mx : tg)) : s.t;
    s.done = 1'b0;
    if (!s.ramp) begin
      s.el   = 0;
      s.ramp = (nt != s.v);
    end else if (en && s.el == div - 1) begin
      s.el = 0;
      diff = s.t - s.v;
      if (diff <= stp && diff >= -stp) begin
        s.v    = s.t;
        s.ramp = (nt != s.v);
        s.done = !s.ramp;
      end else begin
        s.v = s.v + ((diff > 0) ? stp : -stp);
      end
    end else if (s.t == s.v) begin
      s.el   = 0;
      s.ramp = (nt != s.v);
      s.done = !s.ramp;
    end else if (en) begin
      s.el++;
    end
    s.t    = nt;
    s.busy = (s.t != s.v);
    return s;
  endfunction

  vec_t    tbl[16];
  mstate_t ma, mb;
  int      n;

  initial begin
    a_target = '0; b_target = '0; a_ld = 0; b_ld = 0; a_en = 1; b_en = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_a_value", a_value, 0);
    chk("reset_a_busy", a_busy, 0);
    chk("reset_a_done", a_done, 0);
    chk("reset_b_value_init_clamped", b_value, 10);
    @(negedge clk) rst_n = 1'b1;

    // Ramp 0 -> 3 with DIVIDER=4, then a load equal to value.
    tbl[0] = mkv(1, 3, 0, 1, 0);
    for (int i = 1; i < 4; i++)  tbl[i] = mkv(0, 0, 0, 1, 0);
    for (int i = 4; i < 8; i++)  tbl[i] = mkv(0, 0, 1, 1, 0);
    for (int i = 8; i < 12; i++) tbl[i] = mkv(0, 0, 2, 1, 0);
    tbl[12] = mkv(0, 0, 3, 0, 1);
    tbl[13] = mkv(0, 0, 3, 0, 0);
    tbl[14] = mkv(1, 3, 3, 0, 0);
    tbl[15] = mkv(0, 0, 3, 0, 0);
    for (int i = 0; i < 16; i++) begin
      a_ld = tbl[i].ld; a_target = tbl[i].tgt; a_en = tbl[i].en;
      tick_n(1);
      $display("vec %0d ld=%0b tgt=%0d -> value=%0d busy=%0b done=%0b",
               i, tbl[i].ld, tbl[i].tgt, a_value, a_busy, a_done);
      chk($sformatf("vec%0d_value", i), a_value, tbl[i].ev);
      chk($sformatf("vec%0d_busy", i), a_busy, tbl[i].eb);
      chk($sformatf("vec%0d_done", i), a_done, tbl[i].ed);
    end
    a_ld = 0;

    // Reverse mid-ramp: 3 -> 100, retarget to 20 just after reaching 40.
    a_ld = 1; a_target = 100;
    tick_n(1);
    a_ld = 0;
    n = 0;
    while (a_value !== 8'd40 && n < 400) begin
      tick_n(1);
      n++;
    end
    chk("rev_reach_40", a_value, 40);
    a_ld = 1; a_target = 20;
    tick_n(1);
    a_ld = 0;
    chk("rev_busy", a_busy, 1);
    tick_n(2);
    chk("rev_hold_40", a_value, 40);
    tick_n(1);
    $display("reverse: first step after retarget value=%0d", a_value);
    chk("rev_first_down_step", a_value, 39);
    wait_done(0, 200, n);
    chk("rev_step_spacing", n, 76);
    chk("rev_final_value", a_value, 20);

    // Enable freeze mid-interval, then resume with the remaining count.
    a_ld = 1; a_target = 22;
    tick_n(1);
    a_ld = 0;
    tick_n(4);
    chk("en_first_step", a_value, 21);
    tick_n(2);
    a_en = 0;
    tick_n(10);
    chk("en_frozen_value", a_value, 21);
    chk("en_frozen_busy", a_busy, 1);
    a_en = 1;
    tick_n(1);
    chk("en_resume_hold", a_value, 21);
    tick_n(1);
    $display("enable resume: value=%0d done=%0b", a_value, a_done);
    chk("en_resume_step", a_value, 22);
    chk("en_resume_done", a_done, 1);

    // Load coinciding with a tick: step uses the old target.
    a_ld = 1; a_target = 25;
    tick_n(1);
    a_ld = 0;
    tick_n(4);
    chk("lt_first_step", a_value, 23);
    tick_n(3);
    a_ld = 1; a_target = 0;
    tick_n(1);
    a_ld = 0;
    $display("load+tick: value=%0d", a_value);
    chk("lt_old_target_step", a_value, 24);
    chk("lt_done_low", a_done, 0);
    tick_n(3);
    chk("lt_hold", a_value, 24);
    tick_n(1);
    chk("lt_new_target_step", a_value, 23);

    // Asynchronous reset mid-ramp.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_value", a_value, 0);
    chk("async_rst_a_busy", a_busy, 0);
    chk("async_rst_a_done", a_done, 0);
    chk("async_rst_b_value", b_value, 10);
    @(negedge clk) rst_n = 1'b1;

    // B: overshoot guard 10 -> 17 with STEP=5.
    b_ld = 1; b_target = 17;
    tick_n(1);
    b_ld = 0;
    tick_n(3);
    chk("ovs_step1", b_value, 15);
    chk("ovs_step1_done", b_done, 0);
    tick_n(3);
    $display("overshoot: value=%0d done=%0b busy=%0b", b_value, b_done, b_busy);
    chk("ovs_final", b_value, 17);
    chk("ovs_done", b_done, 1);
    chk("ovs_busy", b_busy, 0);
    tick_n(1);
    chk("ovs_done_one_cycle", b_done, 0);

    // B: clamping of out-of-range loads.
    b_ld = 1; b_target = 250;
    tick_n(1);
    b_ld = 0;
    chk("clamp_hi_busy", b_busy, 1);
    wait_done(1, 500, n);
    chk("clamp_hi_cycles", n, 111);
    chk("clamp_hi_value", b_value, 200);
    b_ld = 1; b_target = 3;
    tick_n(1);
    b_ld = 0;
    wait_done(1, 500, n);
    chk("clamp_lo_cycles", n, 114);
    chk("clamp_lo_value", b_value, 10);

    // Randomized run against the model.
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    ma = '{v: 0, t: 0, ramp: 0, el: 0, busy: 0, done: 0};
    mb = '{v: 10, t: 10, ramp: 0, el: 0, busy: 0, done: 0};
    for (int i = 0; i < 2000; i++) begin
      a_ld = ($urandom % 12) == 0; a_target = 8'($urandom); a_en = ($urandom % 5) != 0;
      b_ld = ($urandom % 12) == 0; b_target = 8'($urandom); b_en = ($urandom % 5) != 0;
      if (($urandom % 4) == 0) a_target = ma.v[7:0];
      ma = mstep(ma, a_ld, int'(a_target), a_en, 4, 1, 0, 255);
      mb = mstep(mb, b_ld, int'(b_target), b_en, 3, 5, 10, 200);
      tick_n(1);
      if (a_ld || b_ld)
        $display("rand %0d: A ld=%0b tgt=%0d value=%0d | B ld=%0b tgt=%0d value=%0d",
                 i, a_ld, a_target, a_value, b_ld, b_target, b_value);
      chk("rand_a_value", a_value, ma.v);
      chk("rand_a_busy", a_busy, ma.busy);
      chk("rand_a_done", a_done, ma.done);
      chk("rand_b_value", b_value, mb.v);
      chk("rand_b_busy", b_busy, mb.busy);
      chk("rand_b_done", b_done, mb.done);
    end
    a_ld = 0; b_ld = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
